// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall requests into a freeze vector,
// sequences boot and exception-redirect windows, counts stall cycles.
module pipe_ctrl #(
    parameter int unsigned BOOT_CYC = 2,
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380
) (
    input  logic        _clk,
    input  logic        _rst,
    input  logic        _stallreq_if,
    input  logic        _stallreq_id,
    input  logic        _stallreq_ex,
    input  logic        _stallreq_mem,
    input  logic        _exc_valid,
    input  logic        _exc_eret,
    input  logic [31:0] _epc,
    output logic [5:0]  stall_,
    output logic        flush_,
    output logic [31:0] excpc_,
    output logic        rstpc_,
    output logic [31:0] stall_cnt_
);

    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_EXC_HOLD = 2'd2;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYC - 1);

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [3:0]  boot_cnt_q;
    logic [31:0] excpc_q;
    logic [31:0] stall_cnt_q;
    logic        exc_take;
    logic [31:0] exc_target;

    assign exc_take   = (state_q == ST_RUN) && _exc_valid;
    assign exc_target = _exc_eret ? _epc : EXC_VEC;

    always_comb begin
        stall_  = '0;
        flush_  = 1'b0;
        excpc_  = excpc_q;
        rstpc_  = (state_q == ST_BOOT);
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (exc_take) begin
                    // exception overrides every stall request
                    flush_  = 1'b1;
                    excpc_  = exc_target;
                    state_d = ST_EXC_HOLD;
                end else if (_stallreq_mem) begin
                    stall_ = 6'b011111;
                end else if (_stallreq_ex) begin
                    stall_ = 6'b001111;
                end else if (_stallreq_id) begin
                    stall_ = 6'b000111;
                end else if (_stallreq_if) begin
                    stall_ = 6'b000011;
                end
            end
            ST_EXC_HOLD: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge _clk or negedge _rst) begin
        if (!_rst) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= '0;
            excpc_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_BOOT && boot_cnt_q != BOOT_LAST)
                boot_cnt_q <= boot_cnt_q + 4'd1;
            if (exc_take)
                excpc_q <= exc_target;
            if (stall_ != '0 && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_ = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: boot, stall priority, exception/ERET,
// counter saturation and asynchronous reset.
module tb_pipe_ctrl;

    logic        _clk = 1'b0;
    logic        _rst;
    logic        _stallreq_if, _stallreq_id, _stallreq_ex, _stallreq_mem;
    logic        _exc_valid, _exc_eret;
    logic [31:0] _epc;
    logic [5:0]  stall_;
    logic        flush_;
    logic [31:0] excpc_;
    logic        rstpc_;
    logic [31:0] stall_cnt_;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.BOOT_CYC(2), .EXC_VEC(32'hBFC00380)) dut (
        ._clk(_clk), ._rst(_rst),
        ._stallreq_if(_stallreq_if), ._stallreq_id(_stallreq_id),
        ._stallreq_ex(_stallreq_ex), ._stallreq_mem(_stallreq_mem),
        ._exc_valid(_exc_valid), ._exc_eret(_exc_eret), ._epc(_epc),
        .stall_(stall_), .flush_(flush_), .excpc_(excpc_),
        .rstpc_(rstpc_), .stall_cnt_(stall_cnt_)
    );

    always #5 _clk = ~_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_rst_vals(input string tag);
        check({tag, "_stall"}, 32'(stall_), 32'h0);
        check({tag, "_flush"}, 32'(flush_), 32'h0);
        check({tag, "_excpc"}, excpc_, 32'h0);
        check({tag, "_rstpc"}, 32'(rstpc_), 32'h1);
        check({tag, "_cnt"}, stall_cnt_, 32'h0);
    endtask

    task automatic next_cyc();
        @(negedge _clk);
    endtask

    task automatic set_req(input logic i_f, input logic i_d, input logic e_x, input logic m_m);
        _stallreq_if  = i_f;
        _stallreq_id  = i_d;
        _stallreq_ex  = e_x;
        _stallreq_mem = m_m;
    endtask

    initial begin
        _rst = 1'b0;
        set_req(0, 0, 0, 0);
        _exc_valid = 0;
        _exc_eret  = 0;
        _epc       = '0;

        // boot: reset for 3 cycles, requests during BOOT must be ignored
        repeat (3) next_cyc();
        #1 check_rst_vals("reset");
        _rst = 1'b1;
        set_req(0, 0, 0, 1);
        _exc_valid = 1;
        #1;
        check("boot0_rstpc", 32'(rstpc_), 32'h1);
        check("boot0_stall", 32'(stall_), 32'h0);
        check("boot0_flush", 32'(flush_), 32'h0);
        next_cyc();
        check("boot1_rstpc", 32'(rstpc_), 32'h1);
        check("boot1_stall", 32'(stall_), 32'h0);
        set_req(0, 0, 0, 0);
        _exc_valid = 0;
        next_cyc();
        #1;
        check("run_rstpc", 32'(rstpc_), 32'h0);
        check("boot_cnt", stall_cnt_, 32'h0);

        // stall priority
        set_req(1, 0, 1, 0);
        #1 check("prio_if_ex", 32'(stall_), 32'h0F);
        next_cyc();
        set_req(1, 0, 0, 0);
        #1 check("prio_if", 32'(stall_), 32'h03);
        next_cyc();
        set_req(1, 1, 0, 1);
        #1 check("prio_mem", 32'(stall_), 32'h1F);
        set_req(1, 1, 0, 0);
        #1 check("prio_id", 32'(stall_), 32'h07);
        set_req(0, 0, 0, 0);
        #1 check("prio_none", 32'(stall_), 32'h00);
        check("cnt_after2", stall_cnt_, 32'd2);

        // exception with concurrent mem stall
        next_cyc();
        set_req(0, 0, 0, 1);
        _exc_valid = 1; _exc_eret = 0; _epc = 32'h12345678;
        #1;
        check("exc_flush", 32'(flush_), 32'h1);
        check("exc_stall", 32'(stall_), 32'h0);
        check("exc_pc", excpc_, 32'hBFC00380);
        next_cyc();
        set_req(0, 1, 0, 0);
        _exc_valid = 0;
        #1;
        check("hold_flush", 32'(flush_), 32'h0);
        check("hold_pc", excpc_, 32'hBFC00380);
        check("hold_stall", 32'(stall_), 32'h0);
        check("exc_nocnt", stall_cnt_, 32'd2);
        next_cyc();
        #1 check("post_hold_stall", 32'(stall_), 32'h07);
        next_cyc();
        set_req(0, 0, 0, 0);
        #1 check("cnt_after3", stall_cnt_, 32'd3);

        // ERET, stale valid during hold, then a fresh exception
        _exc_valid = 1; _exc_eret = 1; _epc = 32'h80001234;
        #1;
        check("eret_flush", 32'(flush_), 32'h1);
        check("eret_pc", excpc_, 32'h80001234);
        next_cyc();
        _epc = 32'h0BADF00D;
        #1;
        check("stale_flush", 32'(flush_), 32'h0);
        check("stale_pc", excpc_, 32'h80001234);
        next_cyc();
        _exc_eret = 0;
        #1;
        check("third_flush", 32'(flush_), 32'h1);
        check("third_pc", excpc_, 32'hBFC00380);
        next_cyc();
        _exc_valid = 0;
        next_cyc();

        // saturation
        force dut.stall_cnt_q = 32'hFFFFFFFE;
        #1 release dut.stall_cnt_q;
        #1 check("sat_preload", stall_cnt_, 32'hFFFFFFFE);
        set_req(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            #1 check($sformatf("sat_%0d", i), stall_cnt_, 32'hFFFFFFFF);
        end

        // asynchronous reset during a stall
        #2 _rst = 1'b0;
        #1 check_rst_vals("rst_stall");
        next_cyc();
        _rst = 1'b1;
        set_req(0, 0, 0, 0);
        next_cyc();
        next_cyc();
        #1 check("reboot_rstpc", 32'(rstpc_), 32'h0);

        // asynchronous reset during EXC_HOLD
        _exc_valid = 1; _exc_eret = 1; _epc = 32'hA0000040;
        next_cyc();
        _exc_valid = 0;
        #1 check("hold2_pc", excpc_, 32'hA0000040);
        #2 _rst = 1'b0;
        #1 check_rst_vals("rst_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It owns the `_stall` and `_flush` inputs of the PC generator and every inter-stage register (`if_id`, `id_ex`, `ex_mem`, `mem_wb`). It also drives the `_rstpc`/`_excpc` redirect inputs of the PC generator. It merges per-stage stall requests into one freeze vector, sequences the boot and exception-redirect windows, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- `BOOT_CYC`, default 2: cycles `rstpc_` stays high after reset release, range 1..15.
- `EXC_VEC`, default 32'hBFC00380: general exception entry address.
- `_clk` in 1: core clock, rising edge.
- `_rst` in 1: reset, asynchronous, active-low.
- `_stallreq_if` in 1: fetch waiting on instruction memory.
- `_stallreq_id` in 1: load-use hazard in decode.
- `_stallreq_ex` in 1: multi-cycle mul/div busy.
- `_stallreq_mem` in 1: data access waiting.
- `_exc_valid` in 1: an exception or ERET is committed in the MEM stage this cycle.
- `_exc_eret` in 1: qualifies `_exc_valid`; 1 means ERET.
- `_epc` in 32: EPC from CP0, used when `_exc_eret`=1.
- `stall_` out 6: freeze vector. Bit0 is PC, bit1 `if_id`, bit2 `id_ex`, bit3 `ex_mem`, bit4 `mem_wb`, bit5 WB.
- `flush_` out 1: clear all inter-stage registers and redirect PC to `excpc_`.
- `excpc_` out 32: redirect target, valid while `flush_`=1.
- `rstpc_` out 1: PC generator loads its reset vector.
- `stall_cnt_` out 32: count of cycles with `stall_`≠0, saturating at 32'hFFFFFFFF.

## Operation
- FSM states: BOOT, RUN, EXC_HOLD. Encoding is free. Reset state is BOOT.
- **BOOT**
  - `rstpc_`=1, `stall_`=0, `flush_`=0.
  - A 4-bit counter runs from 0. When it reaches `BOOT_CYC`-1, the FSM goes to RUN.
  - All requests and exceptions are ignored.
- **RUN**, no exception
  - The freeze vector is chosen by the deepest requesting stage, which wins.
  - mem → 6'b011111.
  - else ex → 6'b001111.
  - else id → 6'b000111.
  - else if → 6'b000011.
  - else 6'b000000.
  - A stage k that freezes keeps stages 0..k held. Stage k+1 receives a bubble, which `if_id`/`id_ex` insert when their stall bit is 1 and the next bit is 0.
- **RUN**, `_exc_valid`=1
  - Set `flush_`=1 and force `stall_`=0; the exception overrides all stall requests.
  - `excpc_` = `_exc_eret` ? `_epc` : `EXC_VEC`.
  - Next state is EXC_HOLD.
- **EXC_HOLD**, exactly 1 cycle
  - `flush_`=0, `stall_`=0.
  - `_exc_valid` is ignored, since it can only be stale: MEM was just flushed.
  - `excpc_` holds the last target.
  - Next state is RUN.
- **excpc_ register**
  - `excpc_` is a combinational mux in the RUN+exception cycle.
  - It is registered into `excpc_q` on that edge and output from `excpc_q` at all other times. Reset value is 0.
- **stall_cnt_**
  - Increments on every edge where `stall_`≠0.
  - It holds at 32'hFFFFFFFF once there.
  - It does not count during flush or BOOT, because `stall_`=0 there.
- **Reset**
  - Asserting `_rst` low at any time, including mid-stall or mid-EXC_HOLD, immediately forces BOOT, the counter to 0, `stall_cnt_`=0, and `excpc_q`=0.

## Timing
- Reset values (while `_rst`=0): `stall_`=0, `flush_`=0, `excpc_`=0, `rstpc_`=1, `stall_cnt_`=0.
- `stall_`, `flush_`, and `excpc_` in the exception cycle are combinational from the current-cycle inputs and state, with zero latency. Stages sample them on the same rising edge.
- The FSM, boot counter, `excpc_q`, and `stall_cnt_` update on the rising edge of `_clk`.
- `rstpc_` stays high for exactly `BOOT_CYC` rising edges after `_rst` deasserts, then drops.
- `flush_` is a single-cycle pulse per exception. Back-to-back exceptions are separated by at least 2 cycles: flush, then hold.
- A stall request arriving in EXC_HOLD takes effect in the next RUN cycle.
- `_exc_valid` arriving in the same cycle as any stall request: flush wins, `stall_`=0, and `stall_cnt_` does not increment.

## Test plan
- **Boot:** hold `_rst`=0 for 3 cycles, then release with `BOOT_CYC`=2 → `rstpc_`=1 for 2 edges then 0, and `stall_`=0 throughout.
- **Stall priority:** in RUN, assert `_stallreq_if`=1 and `_stallreq_ex`=1 → `stall_`=6'b001111. Drop ex → 6'b000011. Drop if → 6'b000000. `stall_cnt_` increments by 2.
- **Exception:** assert `_exc_valid`=1, `_exc_eret`=0, and `_stallreq_mem`=1 for 1 cycle → `flush_`=1, `stall_`=0, `excpc_`=32'hBFC00380. Next cycle `flush_`=0, and `excpc_` still reads 32'hBFC00380.
- **ERET and stale exception:** `_exc_valid`=1, `_exc_eret`=1, `_epc`=32'h80001234 → `excpc_`=32'h80001234. Keep `_exc_valid`=1 for a second cycle → no second `flush_` pulse. A third cycle with `_exc_valid`=1 → `flush_`=1 again.
- **Saturation:** force `stall_cnt_` to 32'hFFFFFFFE, then hold `_stallreq_id` for 3 cycles → the counter reads 32'hFFFFFFFF and stays there.
- **Reset mid-operation:** drive `_rst` low asynchronously (between edges) during a stall, and separately during EXC_HOLD → outputs reach reset values without waiting for a clock edge, and `stall_cnt_`=0.
